// File: rtl/acc_drain.sv
// Drain stage behind the fusion-unit accumulator: it counts the beats in each group,
// requantises the group total, and queues the result toward writeback.
// Define RELU_EN to zero negative results before clamping.
module acc_drain #(
    parameter int ACC_W = 28,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psum_valid,
    output logic                psum_ready,
    input  logic [ACC_W-1:0]    acc_in,
    output logic                acc_clr,
    input  logic [CNT_W-1:0]    cfg_len,
    input  logic [4:0]          cfg_shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                sat,
    output logic                busy
);
    // state   | meaning
    // ACCUM   | accepting partial sums, counting toward the latched length
    // CAPTURE | acc_in holds the group total; write it when the FIFO has room
    localparam logic [0:0] ACCUM   = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    localparam int EW = ACC_W + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [EW-1:0] Q_MAX = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] Q_MIN = ~Q_MAX;

    logic [0:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, len_q, eff_len;
    logic [4:0]         shift_q;
    logic               beat, wr, rd, full, clip;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [OUT_W-1:0]   q;
    logic signed [EW-1:0] ext, rnd, sum, r, r_sel;

    assign psum_ready = (state == ACCUM);
    assign beat       = psum_valid && psum_ready;
    assign full       = (count == (AW + 1)'(DEPTH));
    assign out_valid  = (count != '0);
    assign rd         = out_valid && out_ready;
    assign out_data   = mem[rd_ptr];
    assign busy       = (state == CAPTURE) || (cnt != '0) || out_valid;

    // The first beat of a group sees the live configuration; later beats see the latched copy.
    assign eff_len = (cnt != '0) ? len_q : ((cfg_len == '0) ? CNT_W'(1) : cfg_len);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wr      = 1'b0;
        acc_clr = 1'b0;
        case (state)
            ACCUM: begin
                if (beat) begin
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt_d == eff_len) state_d = CAPTURE;
                end
            end
            default: begin
                if (!full) begin
                    wr      = 1'b1;
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_comb begin
        ext   = $signed({acc_in[ACC_W-1], acc_in});
        rnd   = (shift_q == 5'd0) ? '0 : (EW'(1) << (shift_q - 5'd1));
        sum   = ext + rnd;
        r     = sum >>> shift_q;
`ifdef RELU_EN
        r_sel = r[EW-1] ? '0 : r;
`else
        r_sel = r;
`endif
        clip  = 1'b0;
        q     = r_sel[OUT_W-1:0];
        if (r_sel > Q_MAX) begin
            q    = Q_MAX[OUT_W-1:0];
            clip = 1'b1;
        end else if (r_sel < Q_MIN) begin
            q    = Q_MIN[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ACCUM;
            cnt     <= '0;
            len_q   <= '0;
            shift_q <= '0;
            sat     <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (beat && cnt == '0) begin
                len_q   <= eff_len;
                shift_q <= cfg_shift;
            end
            if (wr && clip) sat <= 1'b1;
        end
    end

    // Fullness is judged on the registered count, so a same-cycle pop never frees the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= q;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !rd)      count <= count + (AW + 1)'(1);
            else if (!wr && rd) count <= count - (AW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain with a behavioural accumulator in the loop.
// Expectations follow RELU_EN when it is defined.
module tb_acc_drain;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic        acc_clr;
    logic [7:0]  cfg_len = 8'd1;
    logic [4:0]  cfg_shift = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        sat;
    logic        busy;
    logic signed [27:0] pe_sum = '0;
    logic signed [27:0] acc;
    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;

    acc_drain dut (
        .clk(clk), .reset(reset), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .acc_in(acc), .acc_clr(acc_clr), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Accumulator model: adds every cycle, clears synchronously on acc_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        acc <= '0;
        else if (acc_clr) acc <= '0;
        else              acc <= acc + pe_sum;
    end

    always_ff @(posedge clk) if (acc_clr) clr_cnt <= clr_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_beat(input int v);
        psum_valid = 1'b1;
        pe_sum     = 28'(v);
        tick();
        psum_valid = 1'b0;
        pe_sum     = '0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (acc_clr !== 1'b0) begin errors++; $display("FAIL reset_acc_clr got %b want 0", acc_clr); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL reset_psum_ready got %b want 1", psum_ready); end
    endtask

    task automatic test_basic();
        int c0;
        cfg_len = 8'd4; cfg_shift = 5'd2;
        c0 = clr_cnt;
        send_beat(10); send_beat(20); send_beat(30); send_beat(-5);
        checks++; if (acc_clr !== 1'b1) begin errors++; $display("FAIL basic_clr_t1 got %b want 1", acc_clr); end
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_t1 got %b want 0", psum_ready); end
        checks++; if (acc !== 28'sd55) begin errors++; $display("FAIL basic_acc got %0d want 55", acc); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 8'd14) begin errors++; $display("FAIL basic_data got %0d want 14", out_data); end
        checks++; if (psum_ready !== 1'b1 || acc_clr !== 1'b0) begin errors++; $display("FAIL basic_t2 ready %b clr %b want 1 0", psum_ready, acc_clr); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", sat); end
        tick();
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL basic_clr_pulses got %0d want 1", clr_cnt - c0); end
        pop_one();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drained valid %b busy %b want 0 0", out_valid, busy); end
    endtask

    task automatic test_sat();
        cfg_len = 8'd1; cfg_shift = 5'd0;
        send_beat(1000);
        tick();
        checks++; if (out_data !== 8'd127) begin errors++; $display("FAIL sat_pos_data got %0d want 127", out_data); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b want 1", sat); end
        pop_one();
        do_reset();
        send_beat(-1000);
        tick();
`ifdef RELU_EN
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL sat_neg_data got %h want 00", out_data); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_neg_flag got %b want 0", sat); end
`else
        checks++; if (out_data !== 8'h80) begin errors++; $display("FAIL sat_neg_data got %h want 80", out_data); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b want 1", sat); end
`endif
        pop_one();
    endtask

    task automatic test_round_neg();
        cfg_len = 8'd2; cfg_shift = 5'd2;
        send_beat(-3); send_beat(-3);
        tick();
`ifdef RELU_EN
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL round_neg got %h want 00", out_data); end
`else
        checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL round_neg got %h want ff", out_data); end
`endif
        pop_one();
    endtask

    task automatic test_back_to_back();
        int w;
        cfg_len = 8'd1; cfg_shift = 5'd0; out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            w = 0;
            while (!psum_ready && w < 20) begin tick(); w++; end
            checks++; if (!psum_ready) begin errors++; $display("FAIL b2b_wait_ready got 0 want 1 group %0d", i); end
            send_beat(i);
        end
        tick(); tick(); tick();
        checks++; if (psum_ready !== 1'b0 || acc_clr !== 1'b0) begin errors++; $display("FAIL b2b_hold ready %b clr %b want 0 0", psum_ready, acc_clr); end
        checks++; if (acc !== 28'sd5) begin errors++; $display("FAIL b2b_acc_held got %0d want 5", acc); end
        checks++; if (out_data !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_head data %0d busy %b want 1 1", out_data, busy); end
        pop_one();
        checks++; if (acc_clr !== 1'b1 || psum_ready !== 1'b0) begin errors++; $display("FAIL b2b_release clr %b ready %b want 1 0", acc_clr, psum_ready); end
        tick();
        checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b want 1", psum_ready); end
        for (int i = 2; i <= 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL b2b_drain valid %b data %0d want 1 %0d", out_valid, out_data, i); end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        cfg_len = 8'd1; cfg_shift = 5'd0;
        send_beat(9);
        tick();
        cfg_len = 8'd4;
        send_beat(7); send_beat(8);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_fifo valid %b data %h want 0 00", out_valid, out_data); end
        checks++; if (busy !== 1'b0 || psum_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ctrl busy %b ready %b want 0 1", busy, psum_ready); end
        checks++; if (acc_clr !== 1'b0 || sat !== 1'b0) begin errors++; $display("FAIL mid_reset_flags clr %b sat %b want 0 0", acc_clr, sat); end
        tick();
        reset = 1'b0;
        tick();
        send_beat(1); send_beat(2); send_beat(3); send_beat(4);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd10) begin errors++; $display("FAIL mid_reset_fresh valid %b data %0d want 1 10", out_valid, out_data); end
        pop_one();
    endtask

    task automatic test_len0();
        cfg_len = 8'd0; cfg_shift = 5'd0;
        send_beat(5);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd5) begin errors++; $display("FAIL len0 valid %b data %0d want 1 5", out_valid, out_data); end
        pop_one();
        cfg_len = 8'd2;
        send_beat(3);
        cfg_len = 8'd3; cfg_shift = 5'd3;
        send_beat(4);
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL cfg_latch_len ready %b want 0", psum_ready); end
        tick();
        checks++; if (out_data !== 8'd7) begin errors++; $display("FAIL cfg_latch_shift got %0d want 7", out_data); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_round_neg();
        test_back_to_back();
        test_reset_mid();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
